// File: rtl/exec_alu_pipe_if.sv
// rtl/exec_alu_pipe_if.sv - operation encoding and handshake bundle for the pipelined ALU
// Codes 20..31 are unassigned; the unit accepts and retires them with a zero result.

package exec_alu_pkg;
   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,
      ALU_SUB   = 5'd1,
      ALU_XOR   = 5'd2,
      ALU_OR    = 5'd3,
      ALU_AND   = 5'd4,
      ALU_SLL   = 5'd5,
      ALU_SRL   = 5'd6,
      ALU_SRA   = 5'd7,
      ALU_SLT   = 5'd8,
      ALU_SLTU  = 5'd9,
      ALU_LUI   = 5'd10,
      ALU_AUIPC = 5'd11,
      ALU_JAL   = 5'd12,
      ALU_JALR  = 5'd13,
      ALU_BEQ   = 5'd14,
      ALU_BNE   = 5'd15,
      ALU_BLT   = 5'd16,
      ALU_BGE   = 5'd17,
      ALU_BLTU  = 5'd18,
      ALU_BGEU  = 5'd19
   } instruction_t;
endpackage

interface exec_alu_pipe_if #(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
);
   import exec_alu_pkg::*;
   localparam int CNT_W = $clog2(STAGES + 1);

   logic                flush_i;
   logic                in_valid_i;
   logic                in_ready_o;
   logic [XLEN-1:0]     val1_i;
   logic [XLEN-1:0]     val2_i;
   instruction_t        inst_i;
   logic [TAG_W-1:0]    tag_i;
   logic                out_valid_o;
   logic                out_ready_i;
   logic [XLEN-1:0]     out_o;
   logic [TAG_W-1:0]    tag_o;
   logic                br_taken_o;
   logic [CNT_W-1:0]    count_o;

   modport master (
      output flush_i, in_valid_i, val1_i, val2_i, inst_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_o, tag_o, br_taken_o, count_o
   );

   modport slave (
      input  flush_i, in_valid_i, val1_i, val2_i, inst_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, out_o, tag_o, br_taken_o, count_o
   );
endinterface

// File: rtl/exec_alu_pipe.sv
// rtl/exec_alu_pipe.sv - integer ALU with STAGES-deep elastic result pipeline
// Result is computed at acceptance; the slots only carry it, so flush/backpressure never touch datapath.

module exec_alu_pipe
   import exec_alu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   exec_alu_pipe_if.slave  bus
);
   localparam int SHW   = $clog2(XLEN);
   localparam int CNT_W = $clog2(STAGES + 1);
   localparam int LAST  = STAGES - 1;

   logic [XLEN-1:0]  opa;
   logic [XLEN-1:0]  opb;
   logic [SHW-1:0]   shamt;
   logic [XLEN-1:0]  result;
   logic             cmp;
   logic             is_cmp;
   logic             is_br;
   logic             br_flag;

   always_comb begin
      opa    = bus.val1_i;
      opb    = bus.val2_i;
      shamt  = opb[SHW-1:0];
      result = '0;
      cmp    = 1'b0;
      is_cmp = 1'b0;
      is_br  = 1'b0;
      case (bus.inst_i)
         ALU_ADD, ALU_AUIPC, ALU_JAL, ALU_JALR: result = opa + opb;
         ALU_SUB:  result = opa - opb;
         ALU_XOR:  result = opa ^ opb;
         ALU_OR:   result = opa | opb;
         ALU_AND:  result = opa & opb;
         ALU_SLL:  result = opa << shamt;
         ALU_SRL:  result = opa >> shamt;
         ALU_SRA:  result = $signed(opa) >>> shamt;
         ALU_LUI:  result = opb;
         ALU_SLT:  begin is_cmp = 1'b1; cmp = $signed(opa) < $signed(opb); end
         ALU_SLTU: begin is_cmp = 1'b1; cmp = opa < opb; end
         ALU_BEQ:  begin is_cmp = 1'b1; is_br = 1'b1; cmp = opa == opb; end
         ALU_BNE:  begin is_cmp = 1'b1; is_br = 1'b1; cmp = opa != opb; end
         ALU_BLT:  begin is_cmp = 1'b1; is_br = 1'b1; cmp = $signed(opa) < $signed(opb); end
         ALU_BGE:  begin is_cmp = 1'b1; is_br = 1'b1; cmp = $signed(opa) >= $signed(opb); end
         ALU_BLTU: begin is_cmp = 1'b1; is_br = 1'b1; cmp = opa < opb; end
         ALU_BGEU: begin is_cmp = 1'b1; is_br = 1'b1; cmp = opa >= opb; end
         default:  result = '0;
      endcase
      if (is_cmp) begin
         result = {{(XLEN-1){1'b0}}, cmp};
      end
      br_flag = is_br & cmp;
   end

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] space;
   logic [XLEN-1:0]   data_q [STAGES];
   logic [TAG_W-1:0]  tag_q  [STAGES];
   logic [STAGES-1:0] br_q;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              retire;

   // space[k]: slot k can be written this cycle (empty, or its occupant moves on)
   always_comb begin
      adv         = '0;
      space       = '0;
      adv[LAST]   = vld[LAST] & bus.out_ready_i;
      space[LAST] = ~vld[LAST] | adv[LAST];
      for (int k = LAST - 1; k >= 0; k--) begin
         adv[k]   = vld[k] & space[k+1];
         space[k] = ~vld[k] | adv[k];
      end
      accept = bus.in_valid_i & space[0] & ~bus.flush_i;
      retire = adv[LAST];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld <= '0;
         cnt <= '0;
      end else if (bus.flush_i) begin
         vld <= '0;
         cnt <= '0;
      end else begin
         if (space[0]) begin
            vld[0] <= accept;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (space[k]) begin
               vld[k] <= adv[k-1];
            end
         end
         if (accept && !retire) begin
            cnt <= cnt + CNT_W'(1);
         end else if (!accept && retire) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   // Payload registers are deliberately not reset; valid bits alone qualify them.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         data_q[0] <= result;
         tag_q[0]  <= bus.tag_i;
         br_q[0]   <= br_flag;
      end
      for (int k = 1; k < STAGES; k++) begin
         if (adv[k-1]) begin
            data_q[k] <= data_q[k-1];
            tag_q[k]  <= tag_q[k-1];
            br_q[k]   <= br_q[k-1];
         end
      end
   end

   assign bus.in_ready_o  = space[0];
   assign bus.out_valid_o = vld[LAST];
   assign bus.out_o       = data_q[LAST];
   assign bus.tag_o       = tag_q[LAST];
   assign bus.br_taken_o  = br_q[LAST];
   assign bus.count_o     = cnt;

endmodule

// File: tb/tb_exec_alu_pipe.sv
// tb/tb_exec_alu_pipe.sv - directed checks of exec_alu_pipe (32-bit/2-stage and 64-bit/1-stage)

module tb_exec_alu_pipe;
   import exec_alu_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   exec_alu_pipe_if #(.XLEN(32), .STAGES(2), .TAG_W(5)) bus_a ();
   exec_alu_pipe_if #(.XLEN(64), .STAGES(1), .TAG_W(5)) bus_b ();

   exec_alu_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut_a (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_a.slave)
   );

   exec_alu_pipe #(.XLEN(64), .STAGES(1), .TAG_W(5)) dut_b (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input instruction_t op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [4:0] t);
      bus_a.in_valid_i = 1'b1;
      bus_a.inst_i     = op;
      bus_a.val1_i     = v1;
      bus_a.val2_i     = v2;
      bus_a.tag_i      = t;
   endtask

   task automatic idle_a();
      bus_a.in_valid_i = 1'b0;
   endtask

   instruction_t b_op   [16];
   logic [31:0]  b_v1   [16];
   logic [31:0]  b_v2   [16];
   logic [4:0]   b_tag  [16];
   logic [31:0]  b_res  [16];
   logic         b_br   [16];
   int           b_n;

   task automatic addv(input instruction_t op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [4:0] t, input logic [31:0] r, input logic br);
      b_op[b_n]  = op;
      b_v1[b_n]  = v1;
      b_v2[b_n]  = v2;
      b_tag[b_n] = t;
      b_res[b_n] = r;
      b_br[b_n]  = br;
      b_n++;
   endtask

   // Streams b_n ops at one per cycle; op i must appear two cycles after it is presented.
   task automatic run_burst();
      bus_a.out_ready_i = 1'b1;
      for (int i = 0; i < b_n + 2; i++) begin
         if (i < b_n) drive_a(b_op[i], b_v1[i], b_v2[i], b_tag[i]);
         else idle_a();
         #1;
         if (i < b_n) check_eq("burst_in_ready", bus_a.in_ready_o, 1);
         if (i >= 2) begin
            check_eq("burst_valid", bus_a.out_valid_o, 1);
            check_eq("burst_out", bus_a.out_o, b_res[i-2]);
            check_eq("burst_tag", bus_a.tag_o, b_tag[i-2]);
            check_eq("burst_br", bus_a.br_taken_o, b_br[i-2]);
         end
         next_cycle();
      end
      check_eq("burst_drained", bus_a.out_valid_o, 0);
      check_eq("burst_count0", bus_a.count_o, 0);
      b_n = 0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      b_n      = 0;
      rst_n    = 1'b0;
      bus_a.flush_i = 1'b0; bus_a.in_valid_i = 1'b0; bus_a.out_ready_i = 1'b1;
      bus_a.val1_i = '0; bus_a.val2_i = '0; bus_a.inst_i = ALU_ADD; bus_a.tag_i = '0;
      bus_b.flush_i = 1'b0; bus_b.in_valid_i = 1'b0; bus_b.out_ready_i = 1'b1;
      bus_b.val1_i = '0; bus_b.val2_i = '0; bus_b.inst_i = ALU_ADD; bus_b.tag_i = '0;

      next_cycle();
      next_cycle();
      check_eq("rst_valid", bus_a.out_valid_o, 0);
      check_eq("rst_count", bus_a.count_o, 0);
      check_eq("rst_valid_b", bus_b.out_valid_o, 0);
      rst_n = 1'b1;
      #1;
      check_eq("rst_in_ready", bus_a.in_ready_o, 1);

      // single add 5+7, tag 3
      drive_a(ALU_ADD, 32'd5, 32'd7, 5'd3);
      #1;
      check_eq("add_in_ready", bus_a.in_ready_o, 1);
      next_cycle();
      idle_a();
      #1;
      check_eq("add_count1", bus_a.count_o, 1);
      check_eq("add_not_yet", bus_a.out_valid_o, 0);
      next_cycle();
      check_eq("add_valid", bus_a.out_valid_o, 1);
      check_eq("add_out", bus_a.out_o, 32'd12);
      check_eq("add_tag", bus_a.tag_o, 5'd3);
      check_eq("add_br", bus_a.br_taken_o, 0);
      check_eq("add_count_hold", bus_a.count_o, 1);
      next_cycle();
      check_eq("add_retired", bus_a.out_valid_o, 0);
      check_eq("add_count0", bus_a.count_o, 0);

      // back-to-back sub / sra / sltu
      addv(ALU_SUB,  32'd3,         32'd5, 5'd1, 32'hFFFF_FFFE, 1'b0);
      addv(ALU_SRA,  32'h8000_0000, 32'd4, 5'd2, 32'hF800_0000, 1'b0);
      addv(ALU_SLTU, 32'd1,         32'd2, 5'd4, 32'd1,         1'b0);
      run_burst();

      // branches, compares, shifts, lui, wrap and an unassigned code
      addv(ALU_BGE,  32'hFFFF_FFFF, 32'd0,         5'd6,  32'd0,         1'b0);
      addv(ALU_BGEU, 32'hFFFF_FFFF, 32'd0,         5'd7,  32'd1,         1'b1);
      addv(ALU_BNE,  32'd4,         32'd4,         5'd8,  32'd0,         1'b0);
      addv(ALU_BEQ,  32'd4,         32'd4,         5'd9,  32'd1,         1'b1);
      addv(ALU_BLT,  32'hFFFF_FFFF, 32'd0,         5'd10, 32'd1,         1'b1);
      addv(ALU_SLT,  32'hFFFF_FFFF, 32'd0,         5'd11, 32'd1,         1'b0);
      addv(ALU_ADD,  32'd1,         32'd0,         5'd12, 32'd1,         1'b0);
      addv(ALU_LUI,  32'd0,         32'h1234_5000, 5'd13, 32'h1234_5000, 1'b0);
      addv(ALU_SRL,  32'h8000_0000, 32'd4,         5'd14, 32'h0800_0000, 1'b0);
      addv(ALU_SLL,  32'd1,         32'h21,        5'd15, 32'd2,         1'b0);
      addv(instruction_t'(5'd31), 32'd5, 32'd5,    5'd16, 32'd0,         1'b0);
      addv(ALU_JALR, 32'hFFFF_FFFF, 32'd1,         5'd17, 32'd0,         1'b0);
      run_burst();

      // fill with backpressure, then drain in order
      bus_a.out_ready_i = 1'b0;
      drive_a(ALU_OR, 32'hF0, 32'h0F, 5'd10);
      #1;
      check_eq("fill_rdy0", bus_a.in_ready_o, 1);
      next_cycle();
      drive_a(ALU_AND, 32'hFF, 32'h3C, 5'd11);
      #1;
      check_eq("fill_rdy1", bus_a.in_ready_o, 1);
      check_eq("fill_cnt1", bus_a.count_o, 1);
      next_cycle();
      drive_a(ALU_XOR, 32'hFF, 32'h0F, 5'd12);
      #1;
      check_eq("full_rdy", bus_a.in_ready_o, 0);
      check_eq("full_cnt", bus_a.count_o, 2);
      check_eq("full_tag", bus_a.tag_o, 5'd10);
      next_cycle();
      check_eq("hold_rdy", bus_a.in_ready_o, 0);
      check_eq("hold_cnt", bus_a.count_o, 2);
      check_eq("hold_tag", bus_a.tag_o, 5'd10);
      check_eq("hold_out", bus_a.out_o, 32'hFF);
      bus_a.out_ready_i = 1'b1;
      #1;
      check_eq("release_rdy", bus_a.in_ready_o, 1);
      next_cycle();
      idle_a();
      #1;
      check_eq("drain1_tag", bus_a.tag_o, 5'd11);
      check_eq("drain1_out", bus_a.out_o, 32'h3C);
      check_eq("drain1_cnt", bus_a.count_o, 2);
      next_cycle();
      check_eq("drain2_tag", bus_a.tag_o, 5'd12);
      check_eq("drain2_out", bus_a.out_o, 32'hF0);
      check_eq("drain2_cnt", bus_a.count_o, 1);
      next_cycle();
      check_eq("drain_done", bus_a.out_valid_o, 0);
      check_eq("drain_cnt0", bus_a.count_o, 0);

      // flush with two ops in flight and a valid input
      bus_a.out_ready_i = 1'b0;
      drive_a(ALU_ADD, 32'd1, 32'd1, 5'd20);
      next_cycle();
      drive_a(ALU_ADD, 32'd2, 32'd2, 5'd21);
      next_cycle();
      drive_a(ALU_ADD, 32'd3, 32'd3, 5'd22);
      bus_a.flush_i = 1'b1;
      #1;
      check_eq("preflush_cnt", bus_a.count_o, 2);
      next_cycle();
      bus_a.flush_i = 1'b0;
      idle_a();
      #1;
      check_eq("flush_valid", bus_a.out_valid_o, 0);
      check_eq("flush_cnt", bus_a.count_o, 0);
      check_eq("flush_rdy", bus_a.in_ready_o, 1);
      bus_a.out_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check_eq("flush_no_ghost", bus_a.out_valid_o, 0);
      end
      drive_a(ALU_ADD, 32'd9, 32'd1, 5'd23);
      next_cycle();
      idle_a();
      next_cycle();
      check_eq("postflush_valid", bus_a.out_valid_o, 1);
      check_eq("postflush_tag", bus_a.tag_o, 5'd23);
      check_eq("postflush_out", bus_a.out_o, 32'd10);
      next_cycle();

      // reset mid-operation overrides a valid input
      bus_a.out_ready_i = 1'b0;
      drive_a(ALU_ADD, 32'd4, 32'd4, 5'd5);
      next_cycle();
      rst_n = 1'b0;
      drive_a(ALU_ADD, 32'd6, 32'd6, 5'd6);
      next_cycle();
      rst_n = 1'b1;
      idle_a();
      #1;
      check_eq("midrst_rdy", bus_a.in_ready_o, 1);
      check_eq("midrst_cnt", bus_a.count_o, 0);
      check_eq("midrst_valid", bus_a.out_valid_o, 0);
      next_cycle();
      check_eq("midrst_valid2", bus_a.out_valid_o, 0);
      bus_a.out_ready_i = 1'b1;

      // 64-bit, one stage: shift amount uses the low six bits
      bus_b.in_valid_i = 1'b1;
      bus_b.inst_i     = ALU_SLL;
      bus_b.val1_i     = 64'd1;
      bus_b.val2_i     = 64'd63;
      bus_b.tag_i      = 5'd1;
      #1;
      check_eq("x64_rdy", bus_b.in_ready_o, 1);
      next_cycle();
      bus_b.val2_i = 64'd64;
      bus_b.tag_i  = 5'd2;
      #1;
      check_eq("x64_sll63_valid", bus_b.out_valid_o, 1);
      check_eq("x64_sll63", bus_b.out_o, 64'h8000_0000_0000_0000);
      check_eq("x64_sll63_tag", bus_b.tag_o, 5'd1);
      next_cycle();
      bus_b.in_valid_i = 1'b0;
      #1;
      check_eq("x64_sll64", bus_b.out_o, 64'd1);
      check_eq("x64_sll64_tag", bus_b.tag_o, 5'd2);
      check_eq("x64_cnt", bus_b.count_o, 1);
      next_cycle();
      check_eq("x64_empty", bus_b.out_valid_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_alu_pipe.md
EXEC_ALU_PIPE -- requirements
Module: exec_alu_pipe

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Parameter STAGES, default 2, pipeline depth and latency in cycles; legal range 1..4.
REQ-003 Parameter TAG_W, default 5, width of the ROB tag carried alongside each op.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, synchronous, active-low.
REQ-006 flush_i  input  1  kill all in-flight ops (mispredict recovery).
REQ-007 in_valid_i  input  1  op presented on val1_i/val2_i/inst_i/tag_i.
REQ-008 in_ready_o  output  1  unit accepts op this cycle.
REQ-009 val1_i  input  XLEN  operand 1 (rs1 or PC).
REQ-010 val2_i  input  XLEN  operand 2 (rs2 or immediate).
REQ-011 inst_i  input  instruction_t  decoded operation.
REQ-012 tag_i  input  TAG_W  ROB tag.
REQ-013 out_valid_o  output  1  result valid.
REQ-014 out_ready_i  input  1  consumer accepts result this cycle.
REQ-015 out_o  output  XLEN  result.
REQ-016 tag_o  output  TAG_W  tag of result.
REQ-017 br_taken_o  output  1  branch condition true; meaningful only when out_valid_o and the op is a br_* op.
REQ-018 count_o  output  $clog2(STAGES+1)  number of valid ops in flight.

Function
REQ-019 Accept: op accepted on a cycle where in_valid_i && in_ready_o && !flush_i.
REQ-020 Compute result combinationally at acceptance, then register it with tag and branch flag through STAGES slots; slot STAGES-1 drives out_*.
REQ-021 Ops: slt/blt signed less-than, sltu/bltu unsigned less-than; sra arithmetic right shift; srl logical right shift; sll left shift; add, auipc, jal, jalr give val1+val2; sub gives val1-val2; xor/or/and bitwise; lui gives val2; beq/bne/bge/bgeu give equal/not-equal/signed >=/unsigned >=.
REQ-022 Shift amount is val2_i[$clog2(XLEN)-1:0]; arithmetic wraps modulo 2^XLEN.
REQ-023 Compare and branch ops produce 1 or 0, zero-extended to XLEN; br_taken_o equals out_o[0] for br_* ops and is 0 for all other ops.
REQ-024 Undefined/other inst_i values produce out_o = 0 and br_taken_o = 0, and are still accepted and retired.
REQ-025 Latency: an op accepted in cycle N with no backpressure is on out_valid_o in cycle N+STAGES.
REQ-026 Retire: an op retires on a cycle where out_valid_o && out_ready_i.
REQ-027 Slot k advances into slot k+1 when slot k+1 is empty or advancing; the last slot advances on retire; the pipeline compresses bubbles.
REQ-028 in_ready_o = !slot0_valid || slot0_advances; purely combinational, no dependency on in_valid_i.
REQ-029 Full pipeline with out_ready_i=0: all slots hold, in_ready_o=0, out_* stable.
REQ-030 Full pipeline with out_ready_i=1: one retire and one accept in the same cycle; throughput 1 op/cycle.
REQ-031 flush_i=1: all valid bits clear at the next edge, the input op is discarded, and no retire is counted; out_valid_o may be 1 during the flush cycle but the consumer shall ignore it.
REQ-032 count_o: +1 on accept, -1 on retire, unchanged if both occur, 0 after flush; never exceeds STAGES.
REQ-033 Data and tag registers in empty slots hold their value and are don't-care; only valid bits are reset.

Reset
REQ-034 While rst_ni=0 at an edge: all slot valid bits = 0, count_o = 0, out_valid_o = 0.
REQ-035 Reset mid-operation discards all in-flight ops; in_ready_o = 1 on the first cycle after rst_ni deasserts.
REQ-036 Reset overrides flush_i and in_valid_i.

Verification
REQ-037 STAGES=2, single add 5+7 with tag 3, out_ready_i=1 -> out_valid_o two cycles later, out_o=12, tag_o=3, count_o 1 then 0.
REQ-038 Back-to-back sub, sra (0x80000000 >>> 4), sltu (1<2) with out_ready_i=1 -> results 0xF8000000-class values in order, 1 op/cycle, in_ready_o held at 1.
REQ-039 Fill pipeline with out_ready_i=0 -> in_ready_o=0 after STAGES accepts, count_o=STAGES; raise out_ready_i -> results drain in issue order, none lost or duplicated.
REQ-040 bge with -1,0 -> br_taken_o=0; bgeu with -1,0 -> br_taken_o=1; bne 4,4 -> 0.
REQ-041 Flush with 2 ops in flight and a valid input -> next cycle out_valid_o=0, count_o=0, and the flushed tags never appear.
REQ-042 XLEN=64, sll 1 by val2=63 -> out_o=0x8000000000000000; val2=64 -> shift 0, out_o=1.
